// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit
// Purpose : WIDTH-bit adder split into WIDTH/SEG segments. Each pipeline stage
//           adds one SEG-bit segment and registers its carry for the next
//           stage. Operand bits that have not been added yet travel forward in
//           skew registers. Finished low sum bits travel forward as deskew
//           data. Flow control is valid/ready with a single global stall.
// Params  : WIDTH - operand and sum width in bits
//           SEG   - bits added per stage (STAGES = WIDTH/SEG)
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous, active-high reset
//           a, b       - operands
//           carry_in   - carry into bit 0
//           in_valid   - input handshake valid
//           in_ready   - input handshake ready
//           sum        - registered sum bits [WIDTH-1:0]
//           carry_out  - registered carry out of bit WIDTH-1
//           out_valid  - output handshake valid
//           out_ready  - output handshake ready
//           overflow   - registered signed overflow, aligned with sum
//                        (present only when PIPELINED_ADDER_OVERFLOW_EN is defined)
module pipelined_adder_nbit #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_adder_nbit: WIDTH must be a positive multiple of SEG");
    end

    logic w_stall;

    // A stall freezes every stage at once. It can only occur while the last
    // stage holds a result, so no bubble can be squeezed out during a stall.
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still waiting to be added when data enters stage k
        localparam int AW = WIDTH - k * SEG;

        logic [AW-1:0]          w_a;
        logic [AW-1:0]          w_b;
        logic                   w_c;
        logic                   w_v;
        logic [SEG:0]           w_seg;
        logic [(k+1)*SEG-1:0]   w_sum_nx;

        logic                   r_v;
        logic                   r_c;
        logic [(k+1)*SEG-1:0]   r_sum;

        if (k == 0) begin : g_first
            assign w_a      = a;
            assign w_b      = b;
            assign w_c      = carry_in;
            assign w_v      = in_valid;
            assign w_sum_nx = w_seg[SEG-1:0];
        end else begin : g_next
            assign w_a      = g_stage[k-1].g_skew.r_a;
            assign w_b      = g_stage[k-1].g_skew.r_b;
            assign w_c      = g_stage[k-1].r_c;
            assign w_v      = g_stage[k-1].r_v;
            assign w_sum_nx = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
        end

        assign w_seg = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_c};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (!w_stall) begin
                r_v   <= w_v;
                r_c   <= w_seg[SEG];
                r_sum <= w_sum_nx;
            end
        end

        // Only the upper, not-yet-added operand bits are carried forward
        if (k < STAGES - 1) begin : g_skew
            logic [AW-SEG-1:0] r_a;
            logic [AW-SEG-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_a[AW-1:SEG];
                    r_b <= w_b[AW-1:SEG];
                end
            end
        end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit;
            // signed overflow is that carry XOR the carry out of the MSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf <= w_a[AW-1] ^ w_b[AW-1] ^ w_seg[SEG-1] ^ w_seg[SEG];
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign carry_out = g_stage[STAGES-1].r_c;
    assign sum       = g_stage[STAGES-1].r_sum;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign overflow  = g_stage[STAGES-1].g_ovf.r_ovf;
`else
    // No overflow tracking in this build
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
module tb_pipelined_adder_nbit;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int ST = W / S;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit, 4-stage DUT
    logic [W-1:0] a, b, sum;
    logic         cin, iv, ir, ov, ordy, co;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic         ovf;
`endif

    pipelined_adder_nbit #(.WIDTH(W), .SEG(S)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(cin), .in_valid(iv),
        .in_ready(ir), .sum(sum), .carry_out(co), .out_valid(ov), .out_ready(ordy)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , .overflow(ovf)
`endif
    );

    // Small instances for exhaustive checks: 4/4 (single stage) and 4/2
    logic [3:0] sa, sb, s1_sum, s2_sum;
    logic       scin, sv, srdy, s1_ir, s1_ov, s1_co, s2_ir, s2_ov, s2_co;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic       s1_ovf, s2_ovf;
`endif

    pipelined_adder_nbit #(.WIDTH(4), .SEG(4)) u_s1 (
        .clk(clk), .rst(rst), .a(sa), .b(sb), .carry_in(scin), .in_valid(sv),
        .in_ready(s1_ir), .sum(s1_sum), .carry_out(s1_co), .out_valid(s1_ov), .out_ready(srdy)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , .overflow(s1_ovf)
`endif
    );

    pipelined_adder_nbit #(.WIDTH(4), .SEG(2)) u_s2 (
        .clk(clk), .rst(rst), .a(sa), .b(sb), .carry_in(scin), .in_valid(sv),
        .in_ready(s2_ir), .sum(s2_sum), .carry_out(s2_co), .out_valid(s2_ov), .out_ready(srdy)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , .overflow(s2_ovf)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    typedef struct {
        logic [W:0] r;    // {carry_out, sum}
        logic       o;    // signed overflow
        int         t;    // cycle the operands were presented
        int         s;    // stall count at that time
    } exp_t;

    exp_t       q[$];
    logic [4:0] q1[$];
    logic [4:0] q2[$];
    int         t1[$];
    int         t2[$];
    int cyc = 0, stall_cnt = 0, n_in = 0, n_out = 0, n1 = 0, n2 = 0;
    logic [W-1:0] p_sum;
    logic         p_co;
    logic         p_stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   sgn;
        cyc++;
        if (rst) begin
            n_in -= q.size();
            q.delete();
            q1.delete(); q2.delete(); t1.delete(); t2.delete();
            p_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(ir), 64'(!(ov && !ordy)));
            if (p_stall) begin
                chk("stall_hold_valid", 64'(ov), 64'(1));
                chk("stall_hold_sum", 64'(sum), 64'(p_sum));
                chk("stall_hold_co", 64'(co), 64'(p_co));
            end
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(ov), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("result", 64'({co, sum}), 64'(e.r));
                    chk("latency", 64'(cyc - e.t), 64'(ST + stall_cnt - e.s));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                    chk("overflow", 64'(ovf), 64'(e.o));
`endif
                    n_out++;
                end
            end
            if (iv && ir) begin
                e.r = 17'(a) + 17'(b) + 17'(cin);
                sgn = int'($signed(a)) + int'($signed(b)) + int'(cin);
                e.o = (sgn > 32767) || (sgn < -32768);
                e.t = cyc;
                e.s = stall_cnt;
                q.push_back(e);
                n_in++;
            end
            p_stall = ov && !ordy;
            if (p_stall) stall_cnt++;
            p_sum = sum;
            p_co  = co;

            // small instances, never stalled
            if (s1_ov) begin
                if (q1.size() == 0) chk("s1_spurious", 64'(s1_ov), 64'(0));
                else begin
                    chk("s1_result", 64'({s1_co, s1_sum}), 64'(q1.pop_front()));
                    chk("s1_latency", 64'(cyc - t1.pop_front()), 64'(1));
                    n1++;
                end
            end
            if (s2_ov) begin
                if (q2.size() == 0) chk("s2_spurious", 64'(s2_ov), 64'(0));
                else begin
                    chk("s2_result", 64'({s2_co, s2_sum}), 64'(q2.pop_front()));
                    chk("s2_latency", 64'(cyc - t2.pop_front()), 64'(2));
                    n2++;
                end
            end
            if (sv && s1_ir) begin
                q1.push_back(5'(sa) + 5'(sb) + 5'(scin));
                t1.push_back(cyc);
            end
            if (sv && s2_ir) begin
                q2.push_back(5'(sa) + 5'(sb) + 5'(scin));
                t2.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int   n;
        logic acc;
        a = va; b = vb; cin = vc; iv = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = ir;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_accept_timeout", 64'(acc), 64'(1));
        iv = 1'b0;
    endtask

    logic [W-1:0] va [10] = '{16'h1234, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h8000,
                              16'h00FF, 16'h000F, 16'hABCD, 16'h7FFF, 16'hFFF0};
    logic [W-1:0] vb [10] = '{16'h4321, 16'h0001, 16'h0000, 16'hFFFF, 16'h8000,
                              16'h0F01, 16'h0001, 16'h1234, 16'h0001, 16'h0010};
    logic         vc [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W:0]   vr [10] = '{17'h05556, 17'h10000, 17'h00000, 17'h1FFFF, 17'h10000,
                              17'h01000, 17'h00010, 17'h0BE01, 17'h08000, 17'h10001};
    logic         vo [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [W:0] got[$];
        logic       gov[$];
        int         gc[$];
        int         lat;
        int         n_chk;
        logic       seen;

        a = '0; b = '0; cin = 1'b0; iv = 1'b0; ordy = 1'b1;
        sa = '0; sb = '0; scin = 1'b0; sv = 1'b0; srdy = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 64'(ov), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_carry_out", 64'(co), 64'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(ir), 64'(1));

        // carry rippling through every stage, latency 4
        send(16'hFFFF, 16'h0001, 1'b0);
        lat = 1;
        while (!ov && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("single_latency", 64'(lat), 64'(4));
        chk("single_sum", 64'(sum), 64'(16'h0000));
        chk("single_carry_out", 64'(co), 64'(1));
        repeat (3) @(posedge clk);
        #1;

        // ten back-to-back transfers, one result per cycle in order
        fork
            begin
                for (int i = 0; i < 10; i++) send(va[i], vb[i], vc[i]);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (ov && ordy) begin
                        got.push_back({co, sum});
                        gc.push_back(c);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                        gov.push_back(ovf);
`else
                        gov.push_back(1'b0);
`endif
                    end
                end
            end
        join
        chk("b2b_count", 64'(got.size()), 64'(10));
        n_chk = (got.size() < 10) ? got.size() : 10;
        for (int i = 0; i < n_chk; i++) begin
            chk($sformatf("b2b_lit_%0d", i), 64'(got[i]), 64'(vr[i]));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            chk($sformatf("b2b_ovf_%0d", i), 64'(gov[i]), 64'(vo[i]));
`endif
        end
        if (n_chk == 10) begin
            chk("b2b_first_cycle", 64'(gc[0]), 64'(4));
            chk("b2b_consecutive", 64'(gc[9] - gc[0]), 64'(9));
        end

        // backpressure: out_ready low for 3 cycles with results pending
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'(i * 16'h1357), 16'(16'hF00F ^ i), 1'(i % 2));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                ordy = 1'b0;
                #1;
                chk("stall_valid_pending", 64'(ov), 64'(1));
                chk("stall_in_ready", 64'(ir), 64'(0));
                repeat (3) @(posedge clk);
                #1;
                ordy = 1'b1;
            end
        join
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("stall_drained", 64'(q.size()), 64'(0));
        chk("stall_no_loss", 64'(n_out), 64'(n_in));

        // reset two cycles after a transfer: operand discarded
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h00FF, 16'h0F01, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(ov), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_pulse_out_valid", 64'(ov), 64'(0));
        chk("rst_pulse_sum", 64'(sum), 64'(0));
        chk("rst_pulse_carry_out", 64'(co), 64'(0));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        chk("rst_pulse_overflow", 64'(ovf), 64'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst_pulse", 64'(ir), 64'(1));
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov) seen = 1'b1;
        end
        chk("no_result_after_rst", 64'(seen), 64'(0));

        // exhaustive 4-bit adders
        @(posedge clk);
        #1;
        for (int x = 0; x < 512; x++) begin
            sa = 4'(x); sb = 4'(x >> 4); scin = 1'(x >> 8); sv = 1'b1;
            @(posedge clk);
            #1;
        end
        sv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("s1_all_results", 64'(n1), 64'(512));
        chk("s2_all_results", 64'(n2), 64'(512));
        chk("final_in_out_balance", 64'(n_out), 64'(n_in));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_adder_nbit.md
PIPELINED_ADDER_NBIT -- requirements
Module: pipelined_adder_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 SHALL have parameter SEG, default 4, meaning bits added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port a  input  WIDTH  operand A, unsigned (two's complement when the overflow flag is compiled in).
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port carry_in  input  1  carry into bit 0.
REQ-008 SHALL have port in_valid  input  1  a, b and carry_in are valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-010 SHALL have port sum  output  WIDTH  result bits [WIDTH-1:0].
REQ-011 SHALL have port carry_out  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port out_valid  output  1  sum and carry_out hold a valid result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-015 Stage k (0..STAGES-1) adds bits [k*SEG+SEG-1:k*SEG] plus stage k-1 registered carry (carry_in for k=0); unadded upper operand bits travel with the stage (skew registers); computed low sum bits travel with it (deskew).
REQ-016 Latency exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-017 Result SHALL equal {carry_out,sum} = a + b + carry_in, modulo 2^(WIDTH+1), zero-extended.
REQ-018 Stall = out_valid && !out_ready; during stall every pipeline register holds, in_ready = 0, sum/carry_out/out_valid stable.
REQ-019 in_ready = !stall (combinational); no bubble insertion when not stalled; empty stages advance regardless of out_ready.
REQ-020 Per-stage valid bit travels with data; bubbles (in_valid=0) propagate as invalid, results never reordered, duplicated or dropped.
REQ-021 sum and carry_out SHALL be don't-care when out_valid=0, but registered (no combinational path from a/b to outputs).
REQ-022 WIDTH not a multiple of SEG, or SEG > WIDTH, SHALL be a compile-time error (elaboration failure).
REQ-023 WIDTH = SEG SHALL yield a single-stage, 1-cycle-latency adder.

Reset
REQ-024 rst=1 SHALL immediately clear all stage valid bits, out_valid=0, sum=0, carry_out=0, without waiting for clk.
REQ-025 In-flight operands at reset SHALL be discarded; no result emerges after reset deassertion.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 Macro PIPELINED_ADDER_OVERFLOW_EN defined: extra port overflow  output  1, registered, = signed two's-complement overflow of a+b+carry_in (carry into MSB XOR carry out of MSB), aligned with sum, reset 0, held during stall.
REQ-028 Macro undefined: no overflow port, no associated logic; all other behaviour identical.

Verification (WIDTH=16, SEG=4 unless stated)
REQ-029 a=0xFFFF, b=0x0001, carry_in=0, single transfer -> out_valid exactly 4 cycles later, sum=0x0000, carry_out=1 (carry crosses all stages).
REQ-030 10 back-to-back transfers incl. a=0x1234,b=0x4321,cin=1 -> 0x5556/co=0, out_ready=1 -> 10 consecutive results in order, one per cycle.
REQ-031 out_ready=0 for 3 cycles while results pending -> in_ready=0, outputs frozen, no loss; after release all results in order.
REQ-032 rst pulse 2 cycles after a transfer of 0x00FF+0x0F01 -> outputs 0 immediately, no out_valid ever for that operand.
REQ-033 With PIPELINED_ADDER_OVERFLOW_EN: a=0x7FFF,b=0x0001,cin=0 -> sum=0x8000, overflow=1; a=0xFFFF,b=0x0001 -> overflow=0.
REQ-034 WIDTH=4, SEG=4 (and SEG=2): exhaustive a,b in 0..15, cin in 0..1 -> every {carry_out,sum} = a+b+cin.
